vga_line_scheduler: RTL and testbench
=====================================

# vga_line_scheduler

Scheduler between the NES PPU pixel stream and the VGA scan-out driver. It shares one single-port 512×15 line RAM (two 256-pixel halves) between a buffered PPU writer and the VGA reader, giving the reader fixed priority slots. It also sequences frame alignment by issuing the driver's `sync` pulse once pending pixels have drained. It sits between the PPU output and the VGA driver's `next_pixel_x`/`pixel` pair, on the single system clock.

## Interface
- `FIFO_DEPTH`, 4 — write FIFO entries (power of two, ≥2); entry = 15-bit pixel + 1-bit line-end flag
- `clk` in 1 — system clock; the only clock
- `reset` in 1 — asynchronous, active-high reset
- `ppu_valid` in 1 — PPU pixel valid
- `ppu_pixel` in 15 — RGB555 pixel {b[14:10], g[9:5], r[4:0]}
- `ppu_line_end` in 1 — qualifies `ppu_pixel` as the last pixel of a scanline
- `ppu_ready` out 1 — FIFO can accept; a transfer occurs when `ppu_valid && ppu_ready`
- `ppu_frame_start` in 1 — one-cycle pulse at the start of a PPU frame
- `next_pixel_x` in 10 — from the VGA driver: bit 9 = half, [8:1] = NES pixel index, bit 0 = phase
- `pixel` out 15 — pixel for the current cycle, to the VGA driver
- `vga_sync` out 1 — one-cycle frame-restart pulse to the VGA driver
- `mem_addr` out 9 — line RAM address
- `mem_we` out 1 — line RAM write enable
- `mem_wdata` out 15 — line RAM write data
- `mem_rdata` in 15 — line RAM read data; valid 1 cycle after the address
- `drop_sticky` out 1 — set when a pixel beyond index 255 was discarded; cleared by `reset` or `vga_sync`

## Operation
- **Slot rule**, every cycle:
  - When `next_pixel_x[0]==0`: read slot. `mem_addr={next_pixel_x[9], next_pixel_x[8:1]}`, `mem_we=0`.
  - Otherwise: write slot. If the FIFO is non-empty and state is RUN or DRAIN, pop the head and drive `mem_we=1`, `mem_addr={wr_half, wr_x}`.
  - Otherwise `mem_we=0`, `mem_addr=0`.
- **Pixel output:** `pixel = rd_q ? mem_rdata : pix_hold`.
  - `rd_q` is the registered read-slot flag.
  - `pix_hold <= pixel` every cycle, so each NES pixel is presented for 2 VGA clocks.
- **Write pointer:** `wr_x` (8-bit) increments after each write.
  - Popped entry with the line-end flag: `wr_x<=0`, `wr_half<=~wr_half`.
  - Pop with `wr_x==255` and no flag: the write is performed and `wr_x` holds at 255. Each subsequent non-flagged pop is suppressed (`mem_we=0`) and sets `drop_sticky`.
- **FSM** (`reset` → IDLE):
  - IDLE: `ppu_ready=1`, accepted pixels are discarded, no writes. `ppu_frame_start` → DRAIN.
  - RUN: `ppu_ready=!full`, pixels are pushed. `ppu_frame_start` → DRAIN.
  - DRAIN: `ppu_ready=0`, pops continue. When the FIFO is empty → SYNC.
  - SYNC: `vga_sync=1` for exactly this cycle; `wr_x<=0`, `wr_half<=0`, `drop_sticky<=0` → RUN.
- `ppu_frame_start` while in DRAIN or SYNC is ignored.
- **FIFO push/pop in the same cycle:** legal at any occupancy. Full plus simultaneous pop still deasserts `ppu_ready`, because `ppu_ready` is registered-state based with no bypass.

## Timing
- **Reset values:**
  - Outputs: `ppu_ready=0` (the IDLE value takes effect the first cycle after reset release), `vga_sync=0`, `mem_we=0`, `mem_addr=0`, `mem_wdata=0`, `pixel=0`, `drop_sticky=0`.
  - Internal: `pix_hold=0`, `rd_q=0`, FIFO empty.
- **Read latency:** `next_pixel_x` at cycle t → `pixel` valid at t+1. This matches the driver's "pixel needed next cycle" contract.
- **Write latency:** a pixel accepted at cycle t is written at the first write slot ≥ t+1.
  - Worst case t+2 with an empty FIFO.
  - Sustained throughput: 1 pixel per 2 clocks.
- **Frame sequence:** `ppu_frame_start` at cycle t → DRAIN at t+1 → SYNC one cycle after the FIFO empties → `vga_sync` high for 1 cycle.
  - Minimum: `vga_sync` at t+2 with an empty FIFO.
- **Reset mid-operation:** the FIFO contents and partial line are discarded immediately, and the block returns to IDLE.

## Configuration
- `VGA_SCHED_STATS_EN`:
  - Defined: adds output `drop_count` (out, 8 bits). It increments on every suppressed write, saturates at 255, and clears on `reset` or `vga_sync`.
  - Undefined: the port and counter are absent; `drop_sticky` is unchanged.

## Test plan
- Reset, then `ppu_frame_start` with an empty FIFO → `vga_sync` pulses exactly 2 cycles later; `pixel=0` until the first read of written data.
- Push 256 pixels (value = index; last flagged `ppu_line_end`) with `next_pixel_x[0]` toggling → RAM addresses 0..255 hold 0..255, `wr_half=1`, `drop_sticky=0`.
- Hold `ppu_valid=1` and stall write slots (`next_pixel_x[0]=0` constant) → after 4 accepts `ppu_ready=0`; no `mem_we` while stalled.
- Drive `next_pixel_x=0x102` after RAM[0x81]=0x7FFF → `pixel=0x7FFF` for the next 2 cycles (`rd_q` path, then `pix_hold`).
- Push 258 unflagged pixels → exactly 2 suppressed writes, `drop_sticky=1` (`drop_count=2` with `VGA_SCHED_STATS_EN`). A subsequent frame start clears both after `vga_sync`.
- Assert `reset` during DRAIN with 3 entries queued → next cycle `mem_we=0`, `vga_sync=0`, FIFO empty; no sync is issued until a new `ppu_frame_start`.

Source files
------------

// File: rtl/vga_line_scheduler.sv
// Line-RAM scheduler: read slot on even next_pixel_x, write slot (FIFO pop) on odd; frame sync after drain.
// Latency: read addr -> pixel 1 clk; accepted pixel -> RAM write at next write slot. Backpressure: ppu_ready from state/full.
// Optional VGA_SCHED_STATS_EN adds a saturating drop_count output.

module vga_line_scheduler_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push_i,
   input  logic [WIDTH-1:0] push_dat_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] head_dat_o,
   output logic             empty_o,
   output logic             full_o
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW:0]      count_q, count_d;
   logic             do_push, do_pop;

   assign empty_o    = (count_q == '0);
   assign full_o     = (count_q == FULL_CNT);
   assign head_dat_o = mem_q[rd_ptr_q];
   assign do_pop     = pop_i && !empty_o;
   assign do_push    = push_i && !full_o;

   always_comb begin
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      if (do_pop) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
      end
      if (do_push) begin
         wr_ptr_d = wr_ptr_q + 1'b1;
      end
      case ({do_push, do_pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem_q[wr_ptr_q] <= push_dat_i;
      end
   end
endmodule

module vga_line_scheduler #(
   parameter int FIFO_DEPTH = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        ppu_valid,
   input  logic [14:0] ppu_pixel,
   input  logic        ppu_line_end,
   output logic        ppu_ready,
   input  logic        ppu_frame_start,
   input  logic [9:0]  next_pixel_x,
   output logic [14:0] pixel,
   output logic        vga_sync,
   output logic [8:0]  mem_addr,
   output logic        mem_we,
   output logic [14:0] mem_wdata,
   input  logic [14:0] mem_rdata,
   output logic        drop_sticky
`ifdef VGA_SCHED_STATS_EN
   ,
   output logic [7:0]  drop_count
`endif
);
   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RUN,
      ST_DRAIN,
      ST_SYNC
   } state_t;

   state_t      state_q, state_d;
   logic [7:0]  wr_x_q, wr_x_d;
   logic        wr_half_q, wr_half_d;
   logic        line_full_q, line_full_d;
   logic        drop_sticky_q, drop_sticky_d;
   logic        rd_q;
   logic [14:0] pix_hold_q;
   logic        drop_event;

   logic        fifo_push, fifo_pop, fifo_empty, fifo_full;
   logic [15:0] fifo_head;

   vga_line_scheduler_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (16)
   ) u_fifo (
      .clk        (clk),
      .reset      (reset),
      .push_i     (fifo_push),
      .push_dat_i ({ppu_line_end, ppu_pixel}),
      .pop_i      (fifo_pop),
      .head_dat_o (fifo_head),
      .empty_o    (fifo_empty),
      .full_o     (fifo_full)
   );

   always_comb begin
      state_d       = state_q;
      wr_x_d        = wr_x_q;
      wr_half_d     = wr_half_q;
      line_full_d   = line_full_q;
      drop_sticky_d = drop_sticky_q;
      drop_event    = 1'b0;
      ppu_ready     = 1'b0;
      vga_sync      = 1'b0;
      fifo_push     = 1'b0;
      fifo_pop      = 1'b0;
      mem_we        = 1'b0;
      mem_addr      = '0;
      mem_wdata     = '0;

      case (state_q)
         ST_IDLE: begin
            ppu_ready = 1'b1;
            if (ppu_frame_start) begin
               state_d = ST_DRAIN;
            end
         end
         ST_RUN: begin
            ppu_ready = !fifo_full;
            fifo_push = ppu_valid && !fifo_full;
            if (ppu_frame_start) begin
               state_d = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            if (fifo_empty) begin
               state_d = ST_SYNC;
            end
         end
         ST_SYNC: begin
            vga_sync      = 1'b1;
            wr_x_d        = '0;
            wr_half_d     = 1'b0;
            line_full_d   = 1'b0;
            drop_sticky_d = 1'b0;
            state_d       = ST_RUN;
         end
         default: state_d = ST_IDLE;
      endcase

      if (!next_pixel_x[0]) begin
         mem_addr = {next_pixel_x[9], next_pixel_x[8:1]};
      end else if (!fifo_empty && (state_q == ST_RUN || state_q == ST_DRAIN)) begin
         fifo_pop = 1'b1;
         if (fifo_head[15]) begin
            mem_we      = 1'b1;
            mem_addr    = {wr_half_q, wr_x_q};
            mem_wdata   = fifo_head[14:0];
            wr_x_d      = '0;
            wr_half_d   = ~wr_half_q;
            line_full_d = 1'b0;
         end else if (line_full_q) begin
            // Line already holds 256 pixels: the extra pixel is thrown away.
            drop_event    = 1'b1;
            drop_sticky_d = 1'b1;
         end else begin
            mem_we    = 1'b1;
            mem_addr  = {wr_half_q, wr_x_q};
            mem_wdata = fifo_head[14:0];
            if (wr_x_q == 8'hFF) begin
               line_full_d = 1'b1;
            end else begin
               wr_x_d = wr_x_q + 1'b1;
            end
         end
      end

      if (reset) begin
         ppu_ready = 1'b0;
         mem_we    = 1'b0;
         mem_addr  = '0;
         mem_wdata = '0;
      end
   end

   assign pixel       = rd_q ? mem_rdata : pix_hold_q;
   assign drop_sticky = drop_sticky_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q       <= ST_IDLE;
         wr_x_q        <= '0;
         wr_half_q     <= 1'b0;
         line_full_q   <= 1'b0;
         drop_sticky_q <= 1'b0;
         rd_q          <= 1'b0;
         pix_hold_q    <= '0;
      end else begin
         state_q       <= state_d;
         wr_x_q        <= wr_x_d;
         wr_half_q     <= wr_half_d;
         line_full_q   <= line_full_d;
         drop_sticky_q <= drop_sticky_d;
         rd_q          <= !next_pixel_x[0];
         pix_hold_q    <= pixel;
      end
   end

`ifdef VGA_SCHED_STATS_EN
   logic [7:0] drop_cnt_q, drop_cnt_d;

   always_comb begin
      drop_cnt_d = drop_cnt_q;
      if (vga_sync) begin
         drop_cnt_d = '0;
      end else if (drop_event && drop_cnt_q != 8'hFF) begin
         drop_cnt_d = drop_cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         drop_cnt_q <= '0;
      end else begin
         drop_cnt_q <= drop_cnt_d;
      end
   end

   assign drop_count = drop_cnt_q;
`endif
endmodule

// File: tb/tb_vga_line_scheduler.sv
// Bench for vga_line_scheduler: acts as line RAM and VGA driver, scoreboards every RAM write.
`timescale 1ns/1ps
module tb_vga_line_scheduler;
   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        ppu_valid = 1'b0;
   logic [14:0] ppu_pixel = '0;
   logic        ppu_line_end = 1'b0;
   logic        ppu_frame_start = 1'b0;
   logic [9:0]  next_pixel_x = '0;
   logic        ppu_ready, vga_sync, mem_we, drop_sticky;
   logic [14:0] pixel, mem_wdata;
   logic [8:0]  mem_addr;
   bit   [14:0] mem_rdata;
   bit   [14:0] ram [512];
   logic        poke_en = 1'b0;
   logic [8:0]  poke_addr = '0;
   logic [14:0] poke_dat = '0;
`ifdef VGA_SCHED_STATS_EN
   logic [7:0]  drop_count;
`endif

   int checks = 0;
   int failures = 0;
   int npx_mode = 0;   // 0 toggle, 1 read slots only, 2 hold
   logic [23:0] exp_q [$];
   int  m_idx = 0;
   bit  m_half = 1'b0;
   int  m_drops = 0;
   bit  model_run = 1'b0;
   int  writes_seen = 0;
   int  syncs_seen = 0;

   vga_line_scheduler #(.FIFO_DEPTH(4)) dut (
      .clk             (clk),
      .reset           (reset),
      .ppu_valid       (ppu_valid),
      .ppu_pixel       (ppu_pixel),
      .ppu_line_end    (ppu_line_end),
      .ppu_ready       (ppu_ready),
      .ppu_frame_start (ppu_frame_start),
      .next_pixel_x    (next_pixel_x),
      .pixel           (pixel),
      .vga_sync        (vga_sync),
      .mem_addr        (mem_addr),
      .mem_we          (mem_we),
      .mem_wdata       (mem_wdata),
      .mem_rdata       (mem_rdata),
      .drop_sticky     (drop_sticky)
`ifdef VGA_SCHED_STATS_EN
      ,
      .drop_count      (drop_count)
`endif
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (poke_en) ram[poke_addr] <= poke_dat;
      else if (mem_we) ram[mem_addr] <= mem_wdata;
      mem_rdata <= ram[mem_addr];
   end

   initial begin
      #1000000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   // Reference: the n-th pixel of a line lands at column n; columns past 255 are dropped,
   // a line-end pixel always lands (clamped to 255) and flips the half.
   task automatic model_push(input logic [14:0] d, input logic f);
      logic [7:0] col;
      col = (m_idx > 255) ? 8'hFF : 8'(m_idx);
      if (f) begin
         exp_q.push_back({m_half, col, d});
         m_idx = 0;
         m_half = ~m_half;
      end else if (m_idx > 255) begin
         m_drops++;
         m_idx++;
      end else begin
         exp_q.push_back({m_half, col, d});
         m_idx++;
      end
   endtask

   task automatic sample();
      logic [23:0] e;
      @(negedge clk);
      if (!reset) begin
         if (mem_we) begin
            writes_seen++;
            checks++;
            if (exp_q.size() == 0) begin
               failures++;
               $display("FAIL unexpected_write addr=%h data=%h", mem_addr, mem_wdata);
            end else begin
               e = exp_q.pop_front();
               if ({next_pixel_x[0], mem_addr, mem_wdata} !== {1'b1, e}) begin
                  failures++;
                  $display("FAIL ram_write got slot=%b addr=%h data=%h want slot=1 addr=%h data=%h",
                           next_pixel_x[0], mem_addr, mem_wdata, e[23:15], e[14:0]);
               end
            end
         end
         if (ppu_valid && ppu_ready && model_run) model_push(ppu_pixel, ppu_line_end);
         if (vga_sync) begin
            syncs_seen++;
            model_run = 1'b1;
            m_idx = 0;
            m_half = 1'b0;
            m_drops = 0;
         end
      end
   endtask

   task automatic adv();
      logic [8:0] r;
      @(posedge clk);
      #1;
      r = 9'($urandom);
      if (npx_mode == 0) next_pixel_x = {r, ~next_pixel_x[0]};
      else if (npx_mode == 1) next_pixel_x = {r, 1'b0};
   endtask

   task automatic cyc();
      sample();
      adv();
   endtask

   task automatic push_pixel(input logic [14:0] d, input logic f);
      bit got = 1'b0;
      ppu_valid = 1'b1;
      ppu_pixel = d;
      ppu_line_end = f;
      for (int n = 0; n < 100 && !got; n++) begin
         sample();
         got = ppu_ready;
         adv();
      end
      ppu_valid = 1'b0;
      ppu_line_end = 1'b0;
      if (!got) begin
         checks++;
         failures++;
         $display("FAIL push_accept timeout got=0 want=1");
      end
      repeat ($urandom_range(0, 1)) cyc();
   endtask

   task automatic drain();
      for (int n = 0; n < 3000 && exp_q.size() != 0; n++) cyc();
      repeat (3) cyc();
      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL drain pending=%0d want=0", exp_q.size());
      end
   endtask

   task automatic frame(input int exp_lat);
      int lat = -1;
      npx_mode = 0;
      ppu_frame_start = 1'b1;
      for (int n = 0; n < 3000 && lat < 0; n++) begin
         sample();
         if (vga_sync) lat = n;
         adv();
         ppu_frame_start = 1'b0;
      end
      checks++;
      if ((exp_lat >= 0 && lat != exp_lat) || lat < 0) begin
         failures++;
         $display("FAIL sync_latency got=%0d want=%0d", lat, exp_lat);
      end
      sample();
      checks++;
      if (vga_sync !== 1'b0) begin
         failures++;
         $display("FAIL sync_width got=%b want=0", vga_sync);
      end
      adv();
   endtask

   task automatic test_reset();
      next_pixel_x = 10'h2A4;
      sample();
      checks++; if (ppu_ready !== 1'b0) begin failures++; $display("FAIL rst_ready got=%b want=0", ppu_ready); end
      checks++; if (vga_sync !== 1'b0) begin failures++; $display("FAIL rst_sync got=%b want=0", vga_sync); end
      checks++; if (mem_we !== 1'b0) begin failures++; $display("FAIL rst_we got=%b want=0", mem_we); end
      checks++; if (mem_addr !== 9'h0) begin failures++; $display("FAIL rst_addr got=%h want=0", mem_addr); end
      checks++; if (mem_wdata !== 15'h0) begin failures++; $display("FAIL rst_wdata got=%h want=0", mem_wdata); end
      checks++; if (pixel !== 15'h0) begin failures++; $display("FAIL rst_pixel got=%h want=0", pixel); end
      checks++; if (drop_sticky !== 1'b0) begin failures++; $display("FAIL rst_drop got=%b want=0", drop_sticky); end
      adv();
      reset = 1'b0;
      sample();
      checks++; if (ppu_ready !== 1'b1) begin failures++; $display("FAIL idle_ready got=%b want=1", ppu_ready); end
      adv();
   endtask

   task automatic test_frame_sync();
      frame(2);
      for (int i = 0; i < 6; i++) begin
         sample();
         checks++;
         if (pixel !== 15'h0) begin
            failures++;
            $display("FAIL pixel_before_data got=%h want=0", pixel);
         end
         adv();
      end
   endtask

   task automatic test_line_fill();
      logic [14:0] vals [256];
      logic [14:0] x;
      int mism = 0;
      npx_mode = 0;
      foreach (vals[i]) vals[i] = 15'($urandom);
      for (int i = 0; i < 256; i++) push_pixel(vals[i], i == 255);
      drain();
      for (int i = 0; i < 256; i++) if (ram[i] !== vals[i]) mism++;
      checks++;
      if (mism != 0) begin failures++; $display("FAIL line_fill_ram bad_entries=%0d want=0", mism); end
      checks++;
      if (drop_sticky !== 1'b0) begin failures++; $display("FAIL line_fill_drop got=%b want=0", drop_sticky); end
      x = 15'($urandom);
      push_pixel(x, 1'b0);
      drain();
      checks++;
      if (ram[256] !== x) begin failures++; $display("FAIL second_half got=%h want=%h", ram[256], x); end
   endtask

   task automatic test_stall();
      int acc = 0;
      int we_seen = 0;
      npx_mode = 1;
      adv();
      ppu_valid = 1'b1;
      for (int i = 0; i < 12; i++) begin
         ppu_pixel = 15'($urandom);
         sample();
         if (ppu_valid && ppu_ready) acc++;
         if (mem_we) we_seen++;
         adv();
      end
      sample();
      checks++; if (acc != 4) begin failures++; $display("FAIL stall_accepts got=%0d want=4", acc); end
      checks++; if (ppu_ready !== 1'b0) begin failures++; $display("FAIL stall_ready got=%b want=0", ppu_ready); end
      checks++; if (we_seen != 0) begin failures++; $display("FAIL stall_writes got=%0d want=0", we_seen); end
      ppu_valid = 1'b0;
      npx_mode = 0;
      adv();
      drain();
   endtask

   task automatic test_read_path();
      logic [8:0]  a;
      logic [14:0] d;
      npx_mode = 2;
      for (int k = 0; k < 5; k++) begin
         a = (k == 0) ? 9'h081 : 9'($urandom);
         d = (k == 0) ? 15'h7FFF : 15'($urandom);
         poke_en = 1'b1; poke_addr = a; poke_dat = d;
         next_pixel_x = 10'h001;
         cyc();
         poke_en = 1'b0;
         next_pixel_x = {a, 1'b0};
         sample();
         checks++;
         if (mem_addr !== a || mem_we !== 1'b0) begin
            failures++;
            $display("FAIL read_addr got=%h we=%b want=%h we=0", mem_addr, mem_we, a);
         end
         adv();
         next_pixel_x = {a, 1'b1};
         sample();
         checks++;
         if (pixel !== d) begin failures++; $display("FAIL read_pixel_first got=%h want=%h", pixel, d); end
         adv();
         next_pixel_x = {a + 9'd1, 1'b0};
         sample();
         checks++;
         if (pixel !== d) begin failures++; $display("FAIL read_pixel_hold got=%h want=%h", pixel, d); end
         adv();
      end
      npx_mode = 0;
      adv();
   endtask

   task automatic test_overflow();
      int w0;
      frame(2);
      w0 = writes_seen;
      for (int i = 0; i < 258; i++) push_pixel(15'($urandom), 1'b0);
      drain();
      checks++;
      if (writes_seen - w0 != 256) begin failures++; $display("FAIL ovf_writes got=%0d want=256", writes_seen - w0); end
      checks++;
      if (drop_sticky !== (m_drops > 0)) begin failures++; $display("FAIL ovf_sticky got=%b want=%b", drop_sticky, m_drops > 0); end
`ifdef VGA_SCHED_STATS_EN
      checks++;
      if (drop_count !== 8'(m_drops)) begin failures++; $display("FAIL ovf_count got=%0d want=%0d", drop_count, m_drops); end
`endif
      frame(2);
      checks++;
      if (drop_sticky !== 1'b0) begin failures++; $display("FAIL ovf_sticky_clear got=%b want=0", drop_sticky); end
`ifdef VGA_SCHED_STATS_EN
      checks++;
      if (drop_count !== 8'd0) begin failures++; $display("FAIL ovf_count_clear got=%0d want=0", drop_count); end
`endif
   endtask

   task automatic test_reset_mid();
      int s0;
      int w0;
      int idle_bad = 0;
      npx_mode = 1;
      adv();
      for (int i = 0; i < 3; i++) push_pixel(15'($urandom), 1'b0);
      ppu_frame_start = 1'b1;
      cyc();
      ppu_frame_start = 1'b0;
      cyc();
      reset = 1'b1;
      exp_q.delete();
      model_run = 1'b0;
      m_idx = 0;
      m_half = 1'b0;
      m_drops = 0;
      sample();
      checks++;
      if (mem_we !== 1'b0 || vga_sync !== 1'b0) begin
         failures++;
         $display("FAIL midreset_out got we=%b sync=%b want we=0 sync=0", mem_we, vga_sync);
      end
      adv();
      reset = 1'b0;
      npx_mode = 0;
      s0 = syncs_seen;
      w0 = writes_seen;
      ppu_valid = 1'b1;
      for (int i = 0; i < 20; i++) begin
         ppu_pixel = 15'($urandom);
         sample();
         if (ppu_ready !== 1'b1) idle_bad++;
         adv();
      end
      ppu_valid = 1'b0;
      checks++;
      if (syncs_seen != s0 || writes_seen != w0) begin
         failures++;
         $display("FAIL midreset_quiet got syncs=%0d writes=%0d want 0 0", syncs_seen - s0, writes_seen - w0);
      end
      checks++;
      if (idle_bad != 0) begin failures++; $display("FAIL idle_ready_after_reset bad_cycles=%0d want=0", idle_bad); end
      frame(2);
      push_pixel(15'h1234, 1'b0);
      drain();
      checks++;
      if (ram[0] !== 15'h1234) begin failures++; $display("FAIL post_reset_write got=%h want=1234", ram[0]); end
   endtask

   initial begin
      test_reset();
      test_frame_sync();
      test_line_fill();
      test_stall();
      test_read_path();
      test_overflow();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
